// File: rtl/btn_stepper_pkg.sv
// Shared types and constants for the pushbutton stepper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package btn_stepper_pkg;

  // Per-channel auto-repeat state
  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  localparam int N_BTN = 4;

  // Bit positions of each button within the packed channel vectors
  localparam int R = 0;
  localparam int L = 1;
  localparam int U = 2;
  localparam int D = 3;

endpackage

// File: rtl/btn_stepper_if.sv
// Raw pushbutton pins in, clean step pulses out.
// Latency: n/a (wires only).
// Backpressure: none; steps are fire-and-forget pulses.
interface btn_stepper_if;

  logic btnR_raw;
  logic btnL_raw;
  logic btnU_raw;
  logic btnD_raw;
  logic stepR;
  logic stepL;
  logic stepU;
  logic stepD;

  // Board / stimulus side: drives the pins, consumes the pulses
  modport master (
    output btnR_raw, btnL_raw, btnU_raw, btnD_raw,
    input  stepR, stepL, stepU, stepD
  );

  // Stepper side: samples the pins, produces the pulses
  modport slave (
    input  btnR_raw, btnL_raw, btnU_raw, btnD_raw,
    output stepR, stepL, stepU, stepD
  );

endinterface

// File: rtl/btn_channel.sv
// One button: 2-FF sync, debounce, and typematic repeat FSM producing step pulses.
// Latency: first pulse DEBOUNCE_CYCLES+2 edges after the raw press is first sampled.
// Backpressure: none; each pulse is a single registered cycle.
module btn_channel #(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int REPEAT_DELAY    = 40_000_000,
  parameter int REPEAT_PERIOD   = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic step
);
  import btn_stepper_pkg::*;

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  // Terminal counts; counters clear on reaching these so they never wrap
  localparam logic [DW-1:0] DEB_TERM = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_TERM = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_TERM = RW'(REPEAT_PERIOD - 1);

  logic          s1;
  logic          s;
  logic          deb;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt;
  rpt_state_t    st;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= raw;
      s  <= s1;
    end
  end

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb  <= 1'b0;
      dcnt <= '0;
    end else if (s == deb) begin
      dcnt <= '0;
    end else if (dcnt == DEB_TERM) begin
      deb  <= s;
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

  // Repeat FSM: pulse on press, again after REPEAT_DELAY, then every REPEAT_PERIOD.
  // Release is checked before the terminal count so a release always wins over a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= IDLE;
      rcnt <= '0;
      step <= 1'b0;
    end else begin
      step <= 1'b0;
      case (st)
        IDLE: begin
          if (deb) begin
            step <= 1'b1;
            rcnt <= '0;
            st   <= DELAY;
          end
        end
        DELAY: begin
          if (!deb) begin
            st <= IDLE;
          end else if (rcnt == DLY_TERM) begin
            step <= 1'b1;
            rcnt <= '0;
            st   <= REPEAT;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!deb) begin
            st <= IDLE;
          end else if (rcnt == PER_TERM) begin
            step <= 1'b1;
            rcnt <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn_stepper.sv
// Four independent pushbutton channels turning raw pins into cursor step pulses.
// Latency: DEBOUNCE_CYCLES+2 edges from first sampled press to first step.
// Backpressure: none; opposing presses each pulse and the cursor resolves them.
module btn_stepper #(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int REPEAT_DELAY    = 40_000_000,
  parameter int REPEAT_PERIOD   = 2_000_000
) (
  input  logic          clk,
  input  logic          rst,
  btn_stepper_if.slave  bus
);
  import btn_stepper_pkg::*;

  logic [N_BTN-1:0] raw;
  logic [N_BTN-1:0] step;

  assign raw[R] = bus.btnR_raw;
  assign raw[L] = bus.btnL_raw;
  assign raw[U] = bus.btnU_raw;
  assign raw[D] = bus.btnD_raw;

  // Steps are the channel flops themselves; no logic between flop and pin
  assign bus.stepR = step[R];
  assign bus.stepL = step[L];
  assign bus.stepU = step[U];
  assign bus.stepD = step[D];

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .step (step[i])
    );
  end

endmodule

// File: tb/tb_btn_stepper.sv
// Directed bench for btn_stepper with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Row e drives inputs sampled at edge e; outputs compared #1 after that edge.
// Expected pulse edges are written out by hand from the timing rules.
module tb_btn_stepper;
  import btn_stepper_pkg::*;

  localparam logic [3:0] MR = 4'b0001;
  localparam logic [3:0] ML = 4'b0010;
  localparam logic [3:0] MU = 4'b0100;
  localparam logic [3:0] MD = 4'b1000;
  localparam logic [3:0] M0 = 4'b0000;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  btn_stepper_if bus ();

  btn_stepper #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] btn;
    logic       rst;
    logic [3:0] exp;
    int         tid;
    int         e;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] b, input logic r, input logic [3:0] x,
                     input int tid, input int e);
    vec_t v;
    v.btn = b; v.rst = r; v.exp = x; v.tid = tid; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] b, input logic r);
    bus.btnR_raw = b[R];
    bus.btnL_raw = b[L];
    bus.btnU_raw = b[U];
    bus.btnD_raw = b[D];
    rst = r;
  endtask

  task automatic check(input string nm, input int e, input logic [3:0] x);
    logic [3:0] got;
    got = {bus.stepD, bus.stepU, bus.stepL, bus.stepR};
    n_cmp++;
    if (got !== x) begin
      n_bad++;
      $display("FAIL %s edge %0d: step{D,U,L,R} got %b want %b", nm, e, got, x);
    end
  endtask

  task automatic cyc(input logic [3:0] b, input logic r, input logic [3:0] x,
                     input string nm, input int e);
    drive(b, r);
    @(posedge clk);
    #1;
    check(nm, e, x);
  endtask

  initial begin
    drive(M0, 1'b1);

    // t0: reset holds everything at 0, then a few quiet cycles
    for (int e = 0; e < 3; e++) add(M0, 1'b1, M0, 0, e);
    for (int e = 3; e < 8; e++) add(M0, 1'b0, M0, 0, e);

    // t1: single tap on R, high edges 0..9 -> one pulse after edge 6
    for (int e = 0; e < 25; e++)
      add((e <= 9) ? MR : M0, 1'b0, (e == 6) ? MR : M0, 1, e);

    // t2: hold U edges 0..29 -> pulses 6,16,19,22,25,28,31,34 only
    for (int e = 0; e < 46; e++)
      add((e <= 29) ? MU : M0, 1'b0,
          (e == 6 || e == 16 || e == 19 || e == 22 || e == 25 ||
           e == 28 || e == 31 || e == 34) ? MU : M0, 2, e);

    // t3: L glitches of 3 high / 5 low, ten times -> never a pulse
    for (int e = 0; e < 80; e++)
      add(((e % 8) < 3) ? ML : M0, 1'b0, M0, 3, e);
    for (int e = 80; e < 90; e++) add(M0, 1'b0, M0, 3, e);

    // t4: R and L together edges 0..20 -> both pulse 6,16,19,22,25; none from 27
    for (int e = 0; e < 35; e++)
      add((e <= 20) ? (MR | ML) : M0, 1'b0,
          (e == 6 || e == 16 || e == 19 || e == 22 || e == 25) ? (MR | ML) : M0, 4, e);

    foreach (vecs[i]) begin
      cyc(vecs[i].btn, vecs[i].rst, vecs[i].exp, $sformatf("vec_t%0d", vecs[i].tid), vecs[i].e);
    end

    // t5: D held, reset mid-hold right while a pulse is high
    for (int e = 0; e < 20; e++)
      cyc(MD, 1'b0, (e == 6 || e == 16 || e == 19) ? MD : M0, "rst_pre", e);
    rst = 1'b1;
    #1;
    check("rst_async", 19, M0);
    cyc(MD, 1'b1, M0, "rst_hold", 20);
    cyc(MD, 1'b1, M0, "rst_hold", 21);
    // held button after release of reset behaves as a fresh press at edge 22
    for (int e = 22; e < 46; e++)
      cyc(MD, 1'b0, (e == 28 || e == 38 || e == 41 || e == 44) ? MD : M0, "rst_post", e);
    cyc(M0, 1'b1, M0, "rst_clean", 46);
    cyc(M0, 1'b1, M0, "rst_clean", 47);
    for (int e = 48; e < 51; e++) cyc(M0, 1'b0, M0, "rst_clean", e);

    // t6: R held, 2-cycle low bounces over edges 20..31 must not break the repeat
    for (int e = 0; e < 41; e++)
      cyc((e >= 20 && e <= 31 && (((e - 20) / 2) % 2 == 0)) ? M0 : MR, 1'b0,
          (e == 6 || e == 16 || (e >= 19 && (e - 19) % 3 == 0)) ? MR : M0, "bounce", e);
    cyc(M0, 1'b1, M0, "end_rst", 41);
    cyc(M0, 1'b0, M0, "end_idle", 42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
